updown_counter_param: RTL and testbench

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

---
 rtl/updown_counter_param.sv | 87 ++++++++
 tb/tb_updown_counter_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parameterised up/down counter with modulus, saturation, one-shot and sticky flags
module updown_counter_param #(
    parameter int     WIDTH   = 16,
    parameter longint MODULUS = longint'(1) << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             sat_mode,
    input  logic             one_shot,
    input  logic             clear_flags,
    input  logic [WIDTH-1:0] compare,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic             match,
    output logic             done
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             sticky_ovf_next;
    logic             sticky_unf_next;

    assign done      = (state == DONE);
    assign overflow  = enable & up & ~load & ~done & (count == MAX);
    assign underflow = enable & ~up & ~load & ~done & (count == ZERO);
    assign match     = (count == compare);

    // Boundary events are detected against MAX rather than the natural carry so
    // that a non-power-of-two modulus wraps correctly.
    always_comb begin
        state_next = state;
        count_next = count;
        if (load) begin
            count_next = (load_value > MAX) ? MAX : load_value;
            state_next = RUN;
        end else if (state == RUN && enable) begin
            if (up) begin
                if (count == MAX) begin
                    count_next = sat_mode ? MAX : ZERO;
                    if (one_shot) state_next = DONE;
                end else begin
                    count_next = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    count_next = sat_mode ? ZERO : MAX;
                    if (one_shot) state_next = DONE;
                end else begin
                    count_next = count - ONE;
                end
            end
        end
    end

    // A flag being set on the same edge as a clear request wins over the clear.
    always_comb begin
        sticky_ovf_next = overflow  | (sticky_ovf & ~clear_flags);
        sticky_unf_next = underflow | (sticky_unf & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            count      <= ZERO;
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            sticky_ovf <= sticky_ovf_next;
            sticky_unf <= sticky_unf_next;
        end
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - bench for updown_counter_param (WIDTH=8/MODULUS=200 and default parameters)
module tb_updown_counter_param;
    logic        clk = 1'b0;
    logic        rst, en, up, ld, sat, os, clr;
    logic [15:0] lv, cmp;

    logic [7:0]  a_count;
    logic        a_ovf, a_unf, a_so, a_su, a_match, a_done;
    logic [15:0] b_count;
    logic        b_ovf, b_unf, b_so, b_su, b_match, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .MODULUS(200)) dut_a (
        .clk(clk), .rst(rst), .enable(en), .up(up), .load(ld), .load_value(lv[7:0]),
        .sat_mode(sat), .one_shot(os), .clear_flags(clr), .compare(cmp[7:0]),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf), .sticky_ovf(a_so),
        .sticky_unf(a_su), .match(a_match), .done(a_done)
    );

    updown_counter_param dut_b (
        .clk(clk), .rst(rst), .enable(en), .up(up), .load(ld), .load_value(lv),
        .sat_mode(sat), .one_shot(os), .clear_flags(clr), .compare(cmp),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf), .sticky_ovf(b_so),
        .sticky_unf(b_su), .match(b_match), .done(b_done)
    );

    typedef struct {
        logic        rst, en, up, ld, sat, os, clr;
        logic [15:0] lv, cmp;
        logic        ovf, unf, mt;
        logic [15:0] cnt;
        logic        dn, so, su;
    } vec_t;

    // Reference model: plain integer arithmetic on the count range 0..max.
    longint m_max [2] = '{199, 65535};
    longint m_cnt [2];
    bit     m_done[2], m_so[2], m_su[2];

    function automatic bit m_ovf(int k);
        return en && up && !ld && !m_done[k] && m_cnt[k] == m_max[k];
    endfunction

    function automatic bit m_unf(int k);
        return en && !up && !ld && !m_done[k] && m_cnt[k] == 0;
    endfunction

    task automatic model_step(int k);
        longint n;
        longint lval;
        bit     o, u;
        o = m_ovf(k);
        u = m_unf(k);
        lval = (k == 0) ? longint'(lv[7:0]) : longint'(lv);
        if (rst) begin
            m_cnt[k] = 0; m_done[k] = 0; m_so[k] = 0; m_su[k] = 0;
        end else begin
            if (ld) begin
                m_cnt[k]  = (lval > m_max[k]) ? m_max[k] : lval;
                m_done[k] = 0;
            end else if (!m_done[k] && en) begin
                n = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                if (n > m_max[k] || n < 0) begin
                    if (!sat) m_cnt[k] = (n + m_max[k] + 1) % (m_max[k] + 1);
                    if (os) m_done[k] = 1;
                end else begin
                    m_cnt[k] = n;
                end
            end
            m_so[k] = o || (m_so[k] && !clr);
            m_su[k] = u || (m_su[k] && !clr);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle: combinational outputs checked at the falling edge,
    // registered outputs checked just after the rising edge.
    task automatic apply(vec_t v, bit use_model);
        longint bcmp;
        rst = v.rst; en = v.en; up = v.up; ld = v.ld; sat = v.sat;
        os = v.os; clr = v.clr; lv = v.lv; cmp = v.cmp;
        @(negedge clk);
        bcmp = longint'(cmp);
        if (use_model) begin
            chk("rnd_a_ovf", a_ovf, m_ovf(0));
            chk("rnd_a_unf", a_unf, m_unf(0));
            chk("rnd_a_match", a_match, m_cnt[0] == longint'(cmp[7:0]));
            chk("rnd_b_ovf", b_ovf, m_ovf(1));
            chk("rnd_b_unf", b_unf, m_unf(1));
            chk("rnd_b_match", b_match, m_cnt[1] == bcmp);
        end else begin
            chk("vec_ovf", a_ovf, v.ovf);
            chk("vec_unf", a_unf, v.unf);
            chk("vec_match", a_match, v.mt);
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        if (use_model) begin
            chk("rnd_a_count", a_count, 32'(m_cnt[0]));
            chk("rnd_a_done", a_done, m_done[0]);
            chk("rnd_a_sovf", a_so, m_so[0]);
            chk("rnd_a_sunf", a_su, m_su[0]);
            chk("rnd_b_count", b_count, 32'(m_cnt[1]));
            chk("rnd_b_done", b_done, m_done[1]);
            chk("rnd_b_sovf", b_so, m_so[1]);
            chk("rnd_b_sunf", b_su, m_su[1]);
        end else begin
            chk("vec_count", a_count, v.cnt);
            chk("vec_done", a_done, v.dn);
            chk("vec_sovf", a_so, v.so);
            chk("vec_sunf", a_su, v.su);
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        // rst en up ld sat os clr  lv  cmp | ovf unf mt | cnt dn so su
        tbl.push_back('{0,0,0,1,0,0,0, 197,   0, 0,0,1, 197,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,   0,   0, 0,0,0, 198,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,   0,   0, 0,0,0, 199,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,   0,   0, 1,0,0,   0,0,1,0});
        tbl.push_back('{0,1,1,0,0,0,0,   0,   0, 0,0,1,   1,0,1,0});
        tbl.push_back('{0,0,0,1,0,0,1,   1,   0, 0,0,0,   1,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,0,   0,   0, 0,0,0,   0,0,0,0});
        tbl.push_back('{0,1,0,0,1,0,0,   0,   0, 0,1,1,   0,0,0,1});
        tbl.push_back('{0,1,0,0,1,0,0,   0,   0, 0,1,1,   0,0,0,1});
        tbl.push_back('{0,0,0,1,0,1,0, 198,   0, 0,0,1, 198,0,0,1});
        tbl.push_back('{0,1,1,0,0,1,0,   0,   0, 0,0,0, 199,0,0,1});
        tbl.push_back('{0,1,1,0,0,1,0,   0,   0, 1,0,0,   0,1,1,1});
        tbl.push_back('{0,1,1,0,0,1,0,   0,   0, 0,0,1,   0,1,1,1});
        tbl.push_back('{0,1,0,0,0,0,0,   0,   0, 0,0,1,   0,1,1,1});
        tbl.push_back('{0,0,0,1,0,0,0,   5,   0, 0,0,1,   5,0,1,1});
        tbl.push_back('{0,0,0,1,0,0,0, 250, 199, 0,0,0, 199,0,1,1});
        tbl.push_back('{0,0,0,0,0,0,0,   0, 199, 0,0,1, 199,0,1,1});
        tbl.push_back('{0,1,1,1,0,0,0,  10, 199, 0,0,1,  10,0,1,1});
        tbl.push_back('{0,0,0,1,0,0,1, 199,   0, 0,0,0, 199,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,1,   0,   0, 1,0,0,   0,0,1,0});
        tbl.push_back('{0,0,0,0,0,0,1,   0,   0, 0,0,1,   0,0,0,0});
        tbl.push_back('{0,0,0,1,0,0,0, 120,   0, 0,0,1, 120,0,0,0});
        tbl.push_back('{1,1,1,1,0,0,0,  50,   0, 0,0,0,   0,0,0,0});
        tbl.push_back('{0,1,0,0,0,0,0,   0,   0, 0,1,1, 199,0,0,1});
        tbl.push_back('{0,1,1,0,1,0,0,   0,   0, 1,0,0, 199,0,1,1});
        tbl.push_back('{0,0,0,1,0,0,0,   0,   0, 0,0,0,   0,0,1,1});
        tbl.push_back('{0,1,0,0,1,1,0,   0,   0, 0,1,1,   0,1,1,1});
        tbl.push_back('{1,1,1,0,0,0,0,   0,   0, 0,0,1,   0,0,0,0});
        tbl.push_back('{0,1,1,0,0,0,0,   0,   0, 0,0,1,   1,0,0,0});

        rst = 1; en = 1; up = 1; ld = 1; sat = 0; os = 0; clr = 0; lv = 16'd77; cmp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; en = 0; ld = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_done[k] = 0; m_so[k] = 0; m_su[k] = 0;
        end
        chk("reset_a_count", a_count, 0);
        chk("reset_a_done", a_done, 0);
        chk("reset_a_sovf", a_so, 0);
        chk("reset_a_sunf", a_su, 0);
        chk("reset_b_count", b_count, 0);
        chk("reset_b_done", b_done, 0);

        foreach (tbl[i]) apply(tbl[i], 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rv = tbl[0];
            rv.rst = ($urandom_range(0, 99) == 0);
            rv.en  = ($urandom_range(0, 3) != 0);
            rv.up  = $urandom_range(0, 1) != 0;
            rv.ld  = ($urandom_range(0, 9) == 0);
            rv.sat = ($urandom_range(0, 3) == 0);
            rv.os  = ($urandom_range(0, 7) == 0);
            rv.clr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: rv.lv = 16'($urandom_range(0, 3));
                1: rv.lv = 16'($urandom_range(65531, 65535));
                2: rv.lv = 16'($urandom_range(195, 255));
                default: rv.lv = 16'($urandom);
            endcase
            rv.cmp = ($urandom_range(0, 1) != 0) ? 16'(m_cnt[$urandom_range(0, 1)]) : 16'($urandom);
            apply(rv, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
